// File: rtl/sram_port_arb.sv
// sram_port_arb: merges the boot loader write stream, CPU ibus and CPU dbus onto one single-port SRAM.
// Latency: grant/ready/sram_en are combinational in the request cycle; read data and rvalid follow exactly 1 cycle later.
// Backpressure: loader is never stalled; a CPU master sees ready=0 while it loses arbitration or cke_i is low, and must hold its request.
//
// Ports:
//   clk_i, arst_i (async, active-high), cke_i (global clock enable)
//   boot_i                 boot-mode level; its rising edge restarts loader accounting
//   ldr_*                  loader write channel (highest priority, write only)
//   ibus_*                 instruction read channel (avalid/addr -> ready, rvalid/rdata)
//   dbus_*                 data read/write channel (wstrb=0 means read)
//   sram_*                 single-port SRAM: enable, word address, write data/strobes, read data (1-cycle latency)
//   ldr_cnt_o, ldr_done_o  loader words written since the last boot_i rise, and copy-complete flag
module sram_port_arb #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int SRAM_ADDR_W = 15,
    parameter int CNT_W       = 16
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     cke_i,
    input  logic                     boot_i,

    input  logic                     ldr_avalid_i,
    input  logic [ADDR_W-1:0]        ldr_addr_i,
    input  logic [DATA_W-1:0]        ldr_wdata_i,
    input  logic [DATA_W/8-1:0]      ldr_wstrb_i,

    input  logic                     ibus_avalid_i,
    input  logic [ADDR_W-1:0]        ibus_addr_i,
    output logic [DATA_W-1:0]        ibus_rdata_o,
    output logic                     ibus_rvalid_o,
    output logic                     ibus_ready_o,

    input  logic                     dbus_avalid_i,
    input  logic [ADDR_W-1:0]        dbus_addr_i,
    input  logic [DATA_W-1:0]        dbus_wdata_i,
    input  logic [DATA_W/8-1:0]      dbus_wstrb_i,
    output logic [DATA_W-1:0]        dbus_rdata_o,
    output logic                     dbus_rvalid_o,
    output logic                     dbus_ready_o,

    output logic                     sram_en_o,
    output logic [SRAM_ADDR_W-3:0]   sram_addr_o,
    output logic [DATA_W-1:0]        sram_wdata_o,
    output logic [DATA_W/8-1:0]      sram_wstrb_o,
    input  logic [DATA_W-1:0]        sram_rdata_i,

    output logic [CNT_W-1:0]         ldr_cnt_o,
    output logic                     ldr_done_o
);

    localparam int STRB_W = DATA_W / 8;

    // Which master the SRAM read data of the next cycle belongs to.
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_IBUS = 2'd1,
        OWN_DBUS = 2'd2
    } owner_t;

    owner_t             owner;
    logic               ib_starved;
    logic               boot_q;
    logic [CNT_W-1:0]   ldr_cnt;
    logic               ldr_done;

    logic               ldr_gnt;
    logic               ib_gnt;
    logic               db_gnt;
    logic               ib_rd;
    logic               db_rd;
    logic               boot_rise;

    // Grants are qualified by cke_i: while the block is stalled no access can be
    // accepted, otherwise its owner tag would never be captured and the read lost.
    assign ldr_gnt = cke_i & ldr_avalid_i;
    assign ib_gnt  = cke_i & ~ldr_avalid_i & ibus_avalid_i & (ib_starved | ~dbus_avalid_i);
    assign db_gnt  = cke_i & ~ldr_avalid_i & dbus_avalid_i & ~(ib_starved & ibus_avalid_i);

    assign ib_rd   = ib_gnt;
    assign db_rd   = db_gnt & (dbus_wstrb_i == '0);

    assign boot_rise = boot_i & ~boot_q;

    assign ibus_ready_o = ib_gnt;
    assign dbus_ready_o = db_gnt;

    // SRAM request mux; upper address bits are dropped so accesses wrap modulo SRAM size.
    always_comb begin
        sram_en_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_wstrb_o = '0;
        if (ldr_gnt) begin
            sram_en_o    = 1'b1;
            sram_addr_o  = ldr_addr_i[SRAM_ADDR_W-1:2];
            sram_wdata_o = ldr_wdata_i;
            sram_wstrb_o = ldr_wstrb_i;
        end else if (ib_gnt) begin
            sram_en_o    = 1'b1;
            sram_addr_o  = ibus_addr_i[SRAM_ADDR_W-1:2];
        end else if (db_gnt) begin
            sram_en_o    = 1'b1;
            sram_addr_o  = dbus_addr_i[SRAM_ADDR_W-1:2];
            sram_wdata_o = dbus_wdata_i;
            sram_wstrb_o = dbus_wstrb_i;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            owner      <= OWN_IDLE;
            ib_starved <= 1'b0;
            boot_q     <= 1'b0;
            ldr_cnt    <= '0;
            ldr_done   <= 1'b0;
        end else if (cke_i) begin
            boot_q <= boot_i;

            if (ib_rd)
                owner <= OWN_IBUS;
            else if (db_rd)
                owner <= OWN_DBUS;
            else
                owner <= OWN_IDLE;

            // Loader cycles neither set nor clear the flag: only a real ibus/dbus
            // conflict counts as starvation.
            if (ib_gnt)
                ib_starved <= 1'b0;
            else if (ibus_avalid_i && !ldr_avalid_i)
                ib_starved <= 1'b1;

            // A write in the rising-edge cycle belongs to the new boot session.
            if (boot_rise)
                ldr_cnt <= {{(CNT_W-1){1'b0}}, ldr_gnt};
            else if (ldr_gnt && (ldr_cnt != {CNT_W{1'b1}}))
                ldr_cnt <= ldr_cnt + 1'b1;

            // Count never returns to zero within a session (it saturates), so
            // nonzero means at least one loader write has happened.
            if (boot_rise)
                ldr_done <= 1'b0;
            else if (boot_i && !ldr_avalid_i && (ldr_cnt != '0))
                ldr_done <= 1'b1;
        end
    end

    assign ibus_rvalid_o = (owner == OWN_IBUS);
    assign dbus_rvalid_o = (owner == OWN_DBUS);
    assign ibus_rdata_o  = (owner == OWN_IBUS) ? sram_rdata_i : '0;
    assign dbus_rdata_o  = (owner == OWN_DBUS) ? sram_rdata_i : '0;

    assign ldr_cnt_o  = ldr_cnt;
    assign ldr_done_o = ldr_done;

    // Address bits outside the SRAM window are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ldr_addr_i[ADDR_W-1:SRAM_ADDR_W], ldr_addr_i[1:0],
                                ibus_addr_i[ADDR_W-1:SRAM_ADDR_W], ibus_addr_i[1:0],
                                dbus_addr_i[ADDR_W-1:SRAM_ADDR_W], dbus_addr_i[1:0],
                                STRB_W[0]};

endmodule

// File: tb/tb_sram_port_arb.sv
module tb_sram_port_arb;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int SRAM_ADDR_W = 15;
    localparam int CNT_W       = 16;

    logic                   clk_i = 1'b0;
    logic                   arst_i;
    logic                   cke_i;
    logic                   boot_i;
    logic                   ldr_avalid_i;
    logic [ADDR_W-1:0]      ldr_addr_i;
    logic [DATA_W-1:0]      ldr_wdata_i;
    logic [DATA_W/8-1:0]    ldr_wstrb_i;
    logic                   ibus_avalid_i;
    logic [ADDR_W-1:0]      ibus_addr_i;
    logic [DATA_W-1:0]      ibus_rdata_o;
    logic                   ibus_rvalid_o;
    logic                   ibus_ready_o;
    logic                   dbus_avalid_i;
    logic [ADDR_W-1:0]      dbus_addr_i;
    logic [DATA_W-1:0]      dbus_wdata_i;
    logic [DATA_W/8-1:0]    dbus_wstrb_i;
    logic [DATA_W-1:0]      dbus_rdata_o;
    logic                   dbus_rvalid_o;
    logic                   dbus_ready_o;
    logic                   sram_en_o;
    logic [SRAM_ADDR_W-3:0] sram_addr_o;
    logic [DATA_W-1:0]      sram_wdata_o;
    logic [DATA_W/8-1:0]    sram_wstrb_o;
    logic [DATA_W-1:0]      sram_rdata_i;
    logic [CNT_W-1:0]       ldr_cnt_o;
    logic                   ldr_done_o;

    int compared = 0;
    int mismatched = 0;

    always #5 clk_i = ~clk_i;

    sram_port_arb #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SRAM_ADDR_W(SRAM_ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .boot_i(boot_i),
        .ldr_avalid_i(ldr_avalid_i), .ldr_addr_i(ldr_addr_i),
        .ldr_wdata_i(ldr_wdata_i), .ldr_wstrb_i(ldr_wstrb_i),
        .ibus_avalid_i(ibus_avalid_i), .ibus_addr_i(ibus_addr_i),
        .ibus_rdata_o(ibus_rdata_o), .ibus_rvalid_o(ibus_rvalid_o), .ibus_ready_o(ibus_ready_o),
        .dbus_avalid_i(dbus_avalid_i), .dbus_addr_i(dbus_addr_i),
        .dbus_wdata_i(dbus_wdata_i), .dbus_wstrb_i(dbus_wstrb_i),
        .dbus_rdata_o(dbus_rdata_o), .dbus_rvalid_o(dbus_rvalid_o), .dbus_ready_o(dbus_ready_o),
        .sram_en_o(sram_en_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_wstrb_o(sram_wstrb_o), .sram_rdata_i(sram_rdata_i),
        .ldr_cnt_o(ldr_cnt_o), .ldr_done_o(ldr_done_o)
    );

    // Behavioural single-port SRAM: byte-write, 1-cycle read latency.
    logic [DATA_W-1:0] mem [0:(1<<(SRAM_ADDR_W-2))-1];
    always @(posedge clk_i) begin
        if (sram_en_o) begin
            if (sram_wstrb_o != '0) begin
                for (int b = 0; b < DATA_W/8; b++)
                    if (sram_wstrb_o[b]) mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
            end else begin
                sram_rdata_i <= mem[sram_addr_o];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        ldr_avalid_i  = 1'b0;
        ibus_avalid_i = 1'b0;
        dbus_avalid_i = 1'b0;
        dbus_wstrb_i  = '0;
    endtask

    // Advance to just after the next active edge so new inputs can be driven.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic        ldr;
        logic        ib;
        logic        db;
        logic [3:0]  dstrb;
        logic        exp_ibr;
        logic        exp_dbr;
        logic        exp_en;
        logic [12:0] exp_sa;
        logic        exp_ibv;
        logic        exp_dbv;
    } vec_t;

    vec_t vecs [11];

    initial begin
        // Applied one per cycle; rvalid expectations come from the previous row
        // and grant expectations include the ib_starved history of earlier rows.
        // ibus addr 0x100 -> word 0x40, dbus addr 0x8000_0104 -> 0x41, loader addr 0x208 -> 0x82.
        vecs[0]  = '{0,0,0,4'h0, 0,0,0,13'h00, 0,0};
        vecs[1]  = '{0,1,0,4'h0, 1,0,1,13'h40, 0,0};
        vecs[2]  = '{0,0,1,4'h0, 0,1,1,13'h41, 1,0};
        vecs[3]  = '{0,1,1,4'hF, 0,1,1,13'h41, 0,1};
        vecs[4]  = '{0,1,1,4'h0, 1,0,1,13'h40, 0,0};
        vecs[5]  = '{1,1,1,4'h0, 0,0,1,13'h82, 1,0};
        vecs[6]  = '{0,1,1,4'h0, 0,1,1,13'h41, 0,0};
        vecs[7]  = '{1,1,0,4'h0, 0,0,1,13'h82, 0,1};
        vecs[8]  = '{0,1,1,4'h0, 1,0,1,13'h40, 0,0};
        vecs[9]  = '{0,0,0,4'h0, 0,0,0,13'h00, 1,0};
        vecs[10] = '{0,0,0,4'h0, 0,0,0,13'h00, 0,0};

        arst_i = 1'b1;
        cke_i  = 1'b1;
        boot_i = 1'b0;
        idle_inputs();
        ldr_addr_i   = 32'h0000_0208;
        ldr_wdata_i  = 32'h1234_5678;
        ldr_wstrb_i  = 4'hF;
        ibus_addr_i  = 32'h0000_0100;
        dbus_addr_i  = 32'h8000_0104;
        dbus_wdata_i = 32'hCAFE_0000;
        repeat (2) @(posedge clk_i);
        #1 arst_i = 1'b0;

        // Reset state.
        @(negedge clk_i);
        chk("rst_ibus_rvalid", 64'(ibus_rvalid_o), 64'd0);
        chk("rst_dbus_rvalid", 64'(dbus_rvalid_o), 64'd0);
        chk("rst_ldr_cnt", 64'(ldr_cnt_o), 64'd0);
        chk("rst_ldr_done", 64'(ldr_done_o), 64'd0);
        chk("rst_sram_en", 64'(sram_en_o), 64'd0);
        chk("rst_readys", 64'({ibus_ready_o, dbus_ready_o}), 64'd0);

        // Table-driven arbitration / routing vectors.
        for (int i = 0; i < 11; i++) begin
            next_cycle();
            ldr_avalid_i  = vecs[i].ldr;
            ibus_avalid_i = vecs[i].ib;
            dbus_avalid_i = vecs[i].db;
            dbus_wstrb_i  = vecs[i].dstrb;
            @(negedge clk_i);
            chk($sformatf("vec%0d_ibus_ready", i), 64'(ibus_ready_o), 64'(vecs[i].exp_ibr));
            chk($sformatf("vec%0d_dbus_ready", i), 64'(dbus_ready_o), 64'(vecs[i].exp_dbr));
            chk($sformatf("vec%0d_sram_en", i), 64'(sram_en_o), 64'(vecs[i].exp_en));
            chk($sformatf("vec%0d_sram_addr", i), 64'(sram_addr_o), 64'(vecs[i].exp_sa));
            chk($sformatf("vec%0d_ibus_rvalid", i), 64'(ibus_rvalid_o), 64'(vecs[i].exp_ibv));
            chk($sformatf("vec%0d_dbus_rvalid", i), 64'(dbus_rvalid_o), 64'(vecs[i].exp_dbv));
        end
        // Two loader writes with boot_i=0 are still counted.
        chk("ldr_cnt_boot0", 64'(ldr_cnt_o), 64'd2);

        // Boot image copy of 256 words with both CPU buses requesting.
        next_cycle();
        boot_i = 1'b1;
        next_cycle();
        for (int w = 0; w < 256; w++) begin
            ldr_avalid_i  = 1'b1;
            ldr_addr_i    = 32'(w * 4);
            ldr_wdata_i   = 32'(w);
            ibus_avalid_i = 1'b1;
            dbus_avalid_i = 1'b1;
            @(negedge clk_i);
            if (w == 0) chk("boot_cnt_cleared", 64'(ldr_cnt_o), 64'd0);
            chk("copy_cpu_readys", 64'({ibus_ready_o, dbus_ready_o}), 64'd0);
            chk("copy_sram_en", 64'(sram_en_o), 64'd1);
            next_cycle();
        end
        idle_inputs();
        @(negedge clk_i);
        chk("copy_cnt_256", 64'(ldr_cnt_o), 64'd256);
        chk("copy_done_not_yet", 64'(ldr_done_o), 64'd0);
        next_cycle();
        @(negedge clk_i);
        chk("copy_done", 64'(ldr_done_o), 64'd1);

        // dbus write then ibus read of the same word.
        next_cycle();
        dbus_avalid_i = 1'b1;
        dbus_addr_i   = 32'h0000_0100;
        dbus_wdata_i  = 32'hDEAD_BEEF;
        dbus_wstrb_i  = 4'hF;
        @(negedge clk_i);
        chk("wr_dbus_ready", 64'(dbus_ready_o), 64'd1);
        next_cycle();
        idle_inputs();
        ibus_avalid_i = 1'b1;
        ibus_addr_i   = 32'h0000_0100;
        @(negedge clk_i);
        chk("rd_ibus_ready", 64'(ibus_ready_o), 64'd1);
        chk("wr_no_dbus_rvalid", 64'(dbus_rvalid_o), 64'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        chk("rd_ibus_rvalid", 64'(ibus_rvalid_o), 64'd1);
        chk("rd_ibus_rdata", 64'(ibus_rdata_o), 64'hDEAD_BEEF);
        chk("rd_dbus_rvalid", 64'(dbus_rvalid_o), 64'd0);
        chk("rd_dbus_rdata_zero", 64'(dbus_rdata_o), 64'd0);

        // Continuous contention: dbus, ibus, dbus, ibus ...
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            ibus_avalid_i = 1'b1;
            dbus_avalid_i = 1'b1;
            dbus_wstrb_i  = '0;
            @(negedge clk_i);
            chk($sformatf("alt%0d_dbus_ready", k), 64'(dbus_ready_o), 64'((k % 2) == 0));
            chk($sformatf("alt%0d_ibus_ready", k), 64'(ibus_ready_o), 64'((k % 2) == 1));
            if (k > 0) begin
                chk($sformatf("alt%0d_ibus_rvalid", k), 64'(ibus_rvalid_o), 64'((k % 2) == 0));
                chk($sformatf("alt%0d_dbus_rvalid", k), 64'(dbus_rvalid_o), 64'((k % 2) == 1));
            end
        end
        next_cycle();
        idle_inputs();

        // cke_i low holds the pending rvalid.
        next_cycle();
        ibus_avalid_i = 1'b1;
        next_cycle();
        idle_inputs();
        cke_i = 1'b0;
        @(negedge clk_i);
        chk("cke_hold_rvalid_a", 64'(ibus_rvalid_o), 64'd1);
        next_cycle();
        @(negedge clk_i);
        chk("cke_hold_rvalid_b", 64'(ibus_rvalid_o), 64'd1);
        next_cycle();
        cke_i = 1'b1;
        @(negedge clk_i);
        chk("cke_hold_rvalid_c", 64'(ibus_rvalid_o), 64'd1);
        next_cycle();
        @(negedge clk_i);
        chk("cke_release_rvalid", 64'(ibus_rvalid_o), 64'd0);

        // Counter saturation: 2^CNT_W+3 writes in a fresh boot session.
        next_cycle();
        boot_i = 1'b0;
        next_cycle();
        boot_i = 1'b1;
        next_cycle();
        ldr_avalid_i = 1'b1;
        ldr_addr_i   = 32'h0000_0000;
        repeat ((1 << CNT_W) + 3) next_cycle();
        idle_inputs();
        @(negedge clk_i);
        chk("sat_cnt", 64'(ldr_cnt_o), 64'hFFFF);
        next_cycle();
        @(negedge clk_i);
        chk("sat_done", 64'(ldr_done_o), 64'd1);
        next_cycle();
        boot_i = 1'b0;
        next_cycle();
        boot_i = 1'b1;
        next_cycle();
        @(negedge clk_i);
        chk("rerise_cnt_clear", 64'(ldr_cnt_o), 64'd0);
        chk("rerise_done_clear", 64'(ldr_done_o), 64'd0);

        // Reset in the cycle after a dbus read grant discards its rvalid.
        ldr_avalid_i = 1'b1;
        next_cycle();
        idle_inputs();
        dbus_avalid_i = 1'b1;
        dbus_addr_i   = 32'h0000_0100;
        @(negedge clk_i);
        chk("arst_pre_dbus_ready", 64'(dbus_ready_o), 64'd1);
        chk("arst_pre_cnt", 64'(ldr_cnt_o), 64'd1);
        next_cycle();
        idle_inputs();
        arst_i = 1'b1;
        @(negedge clk_i);
        chk("arst_dbus_rvalid", 64'(dbus_rvalid_o), 64'd0);
        chk("arst_ibus_rvalid", 64'(ibus_rvalid_o), 64'd0);
        chk("arst_cnt", 64'(ldr_cnt_o), 64'd0);
        chk("arst_done", 64'(ldr_done_o), 64'd0);
        next_cycle();
        arst_i = 1'b0;
        @(negedge clk_i);
        chk("arst_after_dbus_rvalid", 64'(dbus_rvalid_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
